i2s_stream_tx: RTL and testbench
================================

Name: i2s_stream_tx

Overview:
Parametrised I2S transmitter for the audio codec path. It accepts stereo PCM samples over a valid/ready stream into a small FIFO, generates BCLK/LRCLK from the system clock, and shifts samples out in standard I2S format (MSB first, one-bit delay after LRCLK). It reports FIFO underruns. It sits between the sample source (beep/tone logic or a DMA) and the codec pins, alongside the codec I2C init block.

Parameters:
DATA_W, 16, sample width per channel; 8..32.
SLOT_W, 32, BCLK periods per channel slot; must be >= DATA_W.
BCLK_DIV, 4, clk cycles per BCLK half-period; must be >= 1.
FIFO_DEPTH, 4, stereo sample entries; power of 2, >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  serialiser enable
s_valid  in  1  sample valid
s_ready  out  1  FIFO not full
s_left  in  DATA_W  left sample, two's complement
s_right  in  DATA_W  right sample
bclk  out  1  I2S bit clock
lrclk  out  1  word select; 0 = left
sdata  out  1  serial data
fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries
underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty

Behaviour:
- Clock and reset: clk and rst are fixed as above (rst asynchronous, active-high).
- Reset values: bclk=0, lrclk=0, sdata=0, underrun=0, fifo_level=0, s_ready=1.
- Reset internal state: divider c=0, bit position f=2*SLOT_W-1, frame register=0.
- Reset mid-operation: returns to reset values immediately; FIFO contents are discarded.
- FIFO:
  - s_ready = (fifo_level != FIFO_DEPTH).
  - Push {s_left, s_right} when s_valid && s_ready.
  - Pop only at a frame load. No bypass: a push and a load in the same cycle with an empty FIFO still counts as an underrun, and the pushed entry is kept.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - s_ready and fifo_level are registered from the FIFO state.
- Divider (en=1):
  - c counts 0..BCLK_DIV-1.
  - At c==BCLK_DIV-1: c<=0 and bclk toggles.
  - A toggle 1->0 is a falling event. All lrclk/sdata/f updates happen only on falling events, registered in that same clk cycle.
- Bit position: on each falling event, f <= (f==2*SLOT_W-1) ? 0 : f+1.
- lrclk for the new f:
  - 1 for f in [SLOT_W-1, 2*SLOT_W-2].
  - 0 for f in [0, SLOT_W-2] and f=2*SLOT_W-1.
  - This gives the one-bit-early LRCLK transition.
- Frame load (falling event producing f=0):
  - If FIFO is non-empty: pop the head into the frame register.
  - If empty: load zeros and pulse underrun for one cycle.
- sdata for the new f:
  - f<DATA_W: left[DATA_W-1-f].
  - SLOT_W<=f<SLOT_W+DATA_W: right[DATA_W-1-(f-SLOT_W)].
  - Otherwise 0 (slot padding).
  - At f=0, sdata takes the MSB of the value being loaded in that same cycle.
- Frame period = 4*SLOT_W*BCLK_DIV clk cycles. The first falling event after en rises occurs 2*BCLK_DIV cycles after en=1 is sampled.
- en=0:
  - c=0, f=2*SLOT_W-1, bclk=lrclk=sdata=0.
  - FIFO is retained and keeps accepting pushes; no underrun pulses.
  - Deasserting en mid-frame abandons that frame; the popped sample is lost.

Optional Feature:
Macro I2S_STREAM_TX_TONE_EN.
- Defined:
  - Adds input port tone_en (1 bit) and parameters TONE_AMP (default 16'h2000, sign-extended/truncated to DATA_W) and TONE_HALF_FRAMES (default 24).
  - While tone_en=1, each frame load takes {+TONE_AMP,+TONE_AMP} or {-TONE_AMP,-TONE_AMP} from an internal square-wave generator. Polarity starts positive and flips every TONE_HALF_FRAMES frames.
  - In tone mode the FIFO is not popped and underrun never pulses.
  - The polarity counter resets on rst or when tone_en=0.
- Undefined: tone_en port and the tone logic are absent. Frame data always comes from the FIFO.

Test Plan:
- Reset/idle: assert rst mid-frame with 3 entries queued -> all outputs 0 next cycle, fifo_level=0, s_ready=1; stays so with en=0.
- Basic frame (DATA_W=16, SLOT_W=32, BCLK_DIV=2): push {16'hA5C3, 16'h3C5A}, raise en:
  - sdata on 16 successive falling events = A5C3 MSB first, then 16 zeros.
  - lrclk rises on the falling event for f=31; right slot = 3C5A.
  - Frame = 256 clk.
- Underrun: en=1 with empty FIFO -> underrun pulses exactly once per frame, sdata all 0; pushing one sample mid-frame -> it plays next frame with no underrun.
- Full/backpressure (FIFO_DEPTH=4): hold s_valid with en=0 -> s_ready drops after 4 pushes, fifo_level=4; enable -> s_ready returns within 1 cycle of the first pop; output order preserved.
- Parameter sweep: DATA_W=24, SLOT_W=24, BCLK_DIV=1, sample 24'h800001 -> no padding bits, lrclk period 48 bclk, bits exact.
- Tone (macro defined, TONE_HALF_FRAMES=2): tone_en=1 -> frames carry 2000,2000,E000,E000,2000… on both channels; FIFO level unchanged.

Source files
------------

// File: rtl/i2s_stream_tx.sv
// I2S transmitter: stereo sample FIFO, BCLK/LRCLK generation and MSB-first serialiser.
// Optional square-wave tone source is built in when I2S_STREAM_TX_TONE_EN is defined.
module i2s_stream_tx #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
`ifdef I2S_STREAM_TX_TONE_EN
  ,
  parameter logic [15:0] TONE_AMP         = 16'h2000,
  parameter int          TONE_HALF_FRAMES = 24
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
`ifdef I2S_STREAM_TX_TONE_EN
  input  logic                            tone_en,
`endif
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_left,
  input  logic [DATA_W-1:0]               s_right,
  output logic                            bclk,
  output logic                            lrclk,
  output logic                            sdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            underrun
);

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int FW = $clog2(2 * SLOT_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] C_LAST = CW'(BCLK_DIV - 1);
  localparam logic [FW-1:0] F_LAST = FW'(2 * SLOT_W - 1);

  logic [CW-1:0]         c;
  logic [FW-1:0]         f;
  logic [FW-1:0]         f_next;
  logic                  fall;
  logic                  load;
  logic                  tone_active;
  logic [2*DATA_W-1:0]   frame_q;
  logic [2*DATA_W-1:0]   load_val;
  logic [2*DATA_W-1:0]   frame_src;
  logic                  lr_next;
  logic                  sd_next;

  logic [2*DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_next;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [2*DATA_W-1:0]   fifo_word;

  // ---------------------------------------------------------------- divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c    <= '0;
      bclk <= 1'b0;
    end else if (!en) begin
      c    <= '0;
      bclk <= 1'b0;
    end else if (c == C_LAST) begin
      c    <= '0;
      bclk <= ~bclk;
    end else begin
      c    <= c + 1'b1;
    end
  end

  assign fall   = en && (c == C_LAST) && bclk;
  assign f_next = (f == F_LAST) ? '0 : f + 1'b1;
  assign load   = fall && (f == F_LAST);

  // ------------------------------------------------------------------- FIFO
  assign push       = s_valid && s_ready;
  assign fifo_empty = (fifo_level == '0);
  assign pop        = load && !tone_active && !fifo_empty;
  assign fifo_word  = fifo_empty ? '0 : mem[rd_ptr];

  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + 1'b1;
      2'b01:   level_next = fifo_level - 1'b1;
      default: level_next = fifo_level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_next;
      s_ready    <= (level_next != LW'(FIFO_DEPTH));
    end
  end

  // Storage has no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_left, s_right};
  end

  // ------------------------------------------------------------ tone source
`ifdef I2S_STREAM_TX_TONE_EN
  localparam int TCW = (TONE_HALF_FRAMES > 1) ? $clog2(TONE_HALF_FRAMES) : 1;
  localparam logic [31:0]       AMP_SX  = {{16{TONE_AMP[15]}}, TONE_AMP};
  localparam logic [DATA_W-1:0] AMP_POS = AMP_SX[DATA_W-1:0];
  localparam logic [DATA_W-1:0] AMP_NEG = -AMP_POS;

  logic [TCW-1:0] tone_cnt;
  logic           tone_neg;

  assign tone_active = tone_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt <= '0;
      tone_neg <= 1'b0;
    end else if (!tone_en) begin
      tone_cnt <= '0;
      tone_neg <= 1'b0;
    end else if (load) begin
      if (tone_cnt == TCW'(TONE_HALF_FRAMES - 1)) begin
        tone_cnt <= '0;
        tone_neg <= ~tone_neg;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    load_val = fifo_word;
    if (tone_en) load_val = tone_neg ? {AMP_NEG, AMP_NEG} : {AMP_POS, AMP_POS};
  end
`else
  assign tone_active = 1'b0;
  assign load_val    = fifo_word;
`endif

  // ------------------------------------------------------------- serialiser
  // At the frame boundary the outgoing MSB comes from the word being loaded.
  assign frame_src = load ? load_val : frame_q;

  always_comb begin
    int fi;
    logic [IW-1:0] idx;
    fi      = int'(f_next);
    idx     = '0;
    sd_next = 1'b0;
    lr_next = (fi >= SLOT_W - 1) && (fi <= 2 * SLOT_W - 2);
    if (fi < DATA_W) begin
      idx     = IW'(2 * DATA_W - 1 - fi);
      sd_next = frame_src[idx];
    end else if ((fi >= SLOT_W) && (fi < SLOT_W + DATA_W)) begin
      idx     = IW'(DATA_W - 1 - (fi - SLOT_W));
      sd_next = frame_src[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f        <= F_LAST;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      frame_q  <= '0;
      underrun <= 1'b0;
    end else if (!en) begin
      f        <= F_LAST;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= load && fifo_empty && !tone_active;
      if (fall) begin
        f     <= f_next;
        lrclk <= lr_next;
        sdata <= sd_next;
        if (load) frame_q <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed bench for i2s_stream_tx: reset, frame format, underrun, backpressure,
// mid-frame reset and a 24-bit/no-padding parameter set.
module tb_i2s_stream_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0, s_valid = 1'b0;
  logic [15:0] s_left = '0, s_right = '0;
  logic        s_ready, bclk, lrclk, sdata, underrun;
  logic [2:0]  fifo_level;

  logic        en2 = 1'b0, s_valid2 = 1'b0;
  logic [23:0] s_left2 = '0, s_right2 = '0;
  logic        s_ready2, bclk2, lrclk2, sdata2, underrun2;
  logic [2:0]  fifo_level2;

`ifdef I2S_STREAM_TX_TONE_EN
  logic tone_en = 1'b0;
`endif

  int n_cmp = 0, n_bad = 0, cyc = 0, ur_count = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_stream_tx #(.DATA_W(16), .SLOT_W(32), .BCLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef I2S_STREAM_TX_TONE_EN
    .tone_en(tone_en),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .fifo_level(fifo_level), .underrun(underrun)
  );

  i2s_stream_tx #(.DATA_W(24), .SLOT_W(24), .BCLK_DIV(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .en(en2),
`ifdef I2S_STREAM_TX_TONE_EN
    .tone_en(tone_en),
`endif
    .s_valid(s_valid2), .s_ready(s_ready2), .s_left(s_left2), .s_right(s_right2),
    .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2), .fifo_level(fifo_level2), .underrun(underrun2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance through n bclk falling events of the selected instance, shifting in
  // sdata/lrclk as seen right after each one (first bit ends up most significant).
  task automatic falls(input int which, input int n, output logic [63:0] v, output logic [63:0] lr);
    int   guard;
    logic last, cur, done;
    v  = '0;
    lr = '0;
    for (int k = 0; k < n; k++) begin
      last  = (which == 0) ? bclk : bclk2;
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        @(negedge clk);
        guard++;
        if (((which == 0) ? underrun : underrun2) === 1'b1) ur_count++;
        cur = (which == 0) ? bclk : bclk2;
        if (last === 1'b1 && cur === 1'b0) done = 1'b1;
        last = cur;
        if (!done && guard > 200) begin
          n_cmp++;
          n_bad++;
          $error("FAIL fall_wait: observed no bclk fall in %0d cycles, expected one", guard);
          return;
        end
      end
      v  = {v[62:0],  (which == 0) ? sdata : sdata2};
      lr = {lr[62:0], (which == 0) ? lrclk : lrclk2};
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] v, v2, lr, lr2;
    logic [15:0] el, er;
    int t, t0;

    // ---- reset values
    repeat (3) @(negedge clk);
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // ---- basic frame
    push(16'hA5C3, 16'h3C5A);
    check("level_after_push", fifo_level, 1);
    en = 1'b1;
    t  = cyc;
    falls(0, 1, v, lr);
    check("first_fall_latency", 64'(cyc - t), 4);
    check("load_level", fifo_level, 0);
    check("load_no_underrun", underrun, 0);
    t0 = cyc;
    v2 = v; lr2 = lr;
    falls(0, 63, v, lr);
    check("frame1_bits", {v2[0], v[62:0]}, 64'hA5C3_0000_3C5A_0000);
    check("frame1_lrclk", {lr2[0], lr[62:0]}, 64'h0000_0001_FFFF_FFFE);

    // ---- underrun frame, then a sample pushed mid-frame plays next frame
    falls(0, 1, v, lr);
    check("frame_period", 64'(cyc - t0), 256);
    check("underrun_pulse", underrun, 1);
    check("underrun_sdata", v[0], 0);
    @(negedge clk);
    check("underrun_one_cycle", underrun, 0);
    ur_count = 0;
    falls(0, 20, v, lr);
    push(16'h1234, 16'h8001);
    falls(0, 43, v2, lr2);
    check("underrun_frame_zero", v | v2, 0);
    falls(0, 64, v, lr);
    check("frame3_bits", v, 64'h1234_0000_8001_0000);
    check("frame3_no_underrun", ur_count, 0);
    check("frame3_level", fifo_level, 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("disabled_outs", {bclk, lrclk, sdata, underrun}, 0);

    // ---- backpressure and order
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_left  = 16'h1000 + 16'(i);
      s_right = 16'h2000 + 16'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("full_level", fifo_level, 4);
    check("full_ready", s_ready, 0);
    en = 1'b1;
    falls(0, 1, v2, lr2);
    check("pop_level", fifo_level, 3);
    check("pop_ready", s_ready, 1);
    falls(0, 63, v, lr);
    check("bp_frame0", {v2[0], v[62:0]}, 64'h1000_0000_2000_0000);
    for (int i = 1; i < 4; i++) begin
      falls(0, 64, v, lr);
      el = 16'h1000 + 16'(i);
      er = 16'h2000 + 16'(i);
      check($sformatf("bp_frame%0d", i), v, {el, 16'h0000, er, 16'h0000});
    end
    en = 1'b0;
    @(negedge clk);

    // ---- reset mid-frame with 3 entries queued
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_left  = 16'h5500 + 16'(i);
      s_right = 16'h6600 + 16'(i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    en = 1'b1;
    falls(0, 10, v, lr);
    check("midframe_level", fifo_level, 3);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("midrst_outs", {bclk, lrclk, sdata, underrun}, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ready", s_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_outs", {bclk, lrclk, sdata, underrun}, 0);
    check("idle_level", fifo_level, 0);

    // ---- 24-bit samples in 24-bit slots, BCLK_DIV=1
    s_left2  = 24'h800001;
    s_right2 = 24'h35A5C3;
    s_valid2 = 1'b1;
    @(negedge clk);
    s_valid2 = 1'b0;
    en2 = 1'b1;
    t   = cyc;
    falls(1, 1, v2, lr2);
    check("sweep_latency", 64'(cyc - t), 2);
    t0 = cyc;
    falls(1, 47, v, lr);
    check("sweep_bits", {16'h0, v2[0], v[46:0]}, {16'h0, 24'h800001, 24'h35A5C3});
    check("sweep_lrclk", {16'h0, lr2[0], lr[46:0]}, 64'h0000_0000_01FF_FFFE);
    falls(1, 1, v, lr);
    check("sweep_period", 64'(cyc - t0), 96);
    check("sweep_underrun", underrun2, 1);
    en2 = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
